// File: rtl/even_cnt_pkg.sv
// Shared types and the even-step prediction rule for the even up-down counter.
package even_cnt_pkg;

    typedef enum logic [1:0] {
        StEmpty,
        StAcq,
        StLock
    } state_e;

    localparam logic [3:0] STEP = 4'd2;

    // Next state of the even counter: +STEP when up, -STEP when down, modulo 16.
    function automatic logic [3:0] next_even(input logic [3:0] q, input logic y);
        return y ? (q - STEP) : (q + STEP);
    endfunction

endpackage

// File: rtl/even_step_predict.sv
// Combinational even-step predictor, reusable by checker and generator alike.
module even_step_predict
    import even_cnt_pkg::*;
(
    input  logic [3:0] q_i,
    input  logic       y_i,
    output logic [3:0] next_o
);

    assign next_o = next_even(q_i, y_i);

endmodule

// File: rtl/even_count_checker.sv
// Locks onto an even up-down counter's Q/Y stream and flags rule violations.
module even_count_checker
    import even_cnt_pkg::*;
#(
    parameter int unsigned LOCK_LEN = 3,
    parameter int unsigned ERR_W    = 8
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             en_i,
    input  logic [3:0]       q_i,
    input  logic             y_i,
    output logic             locked_o,
    output logic             mismatch_o,
    output logic             odd_err_o,
    output logic [ERR_W-1:0] err_count_o,
    output logic [3:0]       expected_o
);

    localparam logic [3:0]       LockLen = 4'(LOCK_LEN);
    localparam logic [ERR_W-1:0] ErrMax  = '1;

    state_e           state_q, state_d;
    logic [3:0]       ref_val_q, ref_val_d;
    logic             ref_dir_q, ref_dir_d;
    logic [3:0]       run_q, run_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic             mismatch_q, mismatch_d;
    logic             odd_q, odd_d;
    logic [3:0]       pred;

    even_step_predict u_predict (
        .q_i    (ref_val_q),
        .y_i    (ref_dir_q),
        .next_o (pred)
    );

    // Next-state logic: compare the new sample against the prediction from the last one.
    always_comb begin
        state_d    = state_q;
        ref_val_d  = ref_val_q;
        ref_dir_d  = ref_dir_q;
        run_d      = run_q;
        err_d      = err_q;
        mismatch_d = 1'b0;
        odd_d      = 1'b0;
        if (en_i) begin
            odd_d     = q_i[0];
            // Every accepted sample becomes the new reference, good or bad.
            ref_val_d = q_i;
            ref_dir_d = y_i;
            unique case (state_q)
                StEmpty: begin
                    run_d   = 4'd0;
                    state_d = StAcq;
                end
                StAcq: begin
                    if (q_i == pred) begin
                        run_d = run_q + 4'd1;
                        if (run_d == LockLen) begin
                            state_d = StLock;
                        end
                    end else begin
                        run_d = 4'd0;
                    end
                end
                StLock: begin
                    if (q_i != pred) begin
                        mismatch_d = 1'b1;
                        if (err_q != ErrMax) begin
                            err_d = err_q + 1'b1;
                        end
                        run_d   = 4'd0;
                        state_d = StAcq;
                    end
                end
                default: state_d = StEmpty;
            endcase
        end
    end

    // State and output registers with synchronous reset taking priority over en.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= StEmpty;
            ref_val_q  <= 4'd0;
            ref_dir_q  <= 1'b0;
            run_q      <= 4'd0;
            err_q      <= '0;
            mismatch_q <= 1'b0;
            odd_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            ref_val_q  <= ref_val_d;
            ref_dir_q  <= ref_dir_d;
            run_q      <= run_d;
            err_q      <= err_d;
            mismatch_q <= mismatch_d;
            odd_q      <= odd_d;
        end
    end

    assign locked_o    = (state_q == StLock);
    assign mismatch_o  = mismatch_q;
    assign odd_err_o   = odd_q;
    assign err_count_o = err_q;
    // No prediction exists until a first sample has been captured.
    assign expected_o  = (state_q == StEmpty) ? 4'd0 : pred;

endmodule

// File: tb/tb_even_count_checker.sv
// Randomized and directed bench for even_count_checker against a rule-level model.
module tb_even_count_checker;

    localparam int unsigned LockLen = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       en = 1'b0;
    logic [3:0] q = 4'd0;
    logic       y = 1'b0;

    logic       locked, mismatch, odd_err;
    logic [7:0] err8;
    logic [3:0] expected;
    logic       locked2, mismatch2, odd_err2;
    logic [1:0] err2;
    logic [3:0] expected2;

    int checks = 0;
    int errors = 0;

    // Rule-level model: whether a reference exists, the last sample, good-run length.
    bit         m_have = 0;
    bit         m_lock = 0;
    logic [3:0] m_ref = 4'd0;
    bit         m_refy = 0;
    int         m_run = 0;
    int         m_errs = 0;
    bit         m_mis = 0;
    bit         m_odd = 0;
    logic [3:0] m_expect = 4'd0;

    always #5 clk = ~clk;

    even_count_checker #(.LOCK_LEN(LockLen), .ERR_W(8)) dut (
        .clk_i       (clk),
        .reset_i     (reset),
        .en_i        (en),
        .q_i         (q),
        .y_i         (y),
        .locked_o    (locked),
        .mismatch_o  (mismatch),
        .odd_err_o   (odd_err),
        .err_count_o (err8),
        .expected_o  (expected)
    );

    even_count_checker #(.LOCK_LEN(LockLen), .ERR_W(2)) dut2 (
        .clk_i       (clk),
        .reset_i     (reset),
        .en_i        (en),
        .q_i         (q),
        .y_i         (y),
        .locked_o    (locked2),
        .mismatch_o  (mismatch2),
        .odd_err_o   (odd_err2),
        .err_count_o (err2),
        .expected_o  (expected2)
    );

    function automatic logic [3:0] predict(input logic [3:0] r, input bit d);
        return 4'((int'(r) + (d ? 14 : 2)) % 16);
    endfunction

    function automatic logic [7:0] sat8(input int n);
        return (n > 255) ? 8'd255 : 8'(n);
    endfunction

    function automatic logic [1:0] sat2(input int n);
        return (n > 3) ? 2'd3 : 2'(n);
    endfunction

    // Drive one cycle, advance the model at the edge, then settle 1 time unit past it.
    task automatic apply(input bit rst, input bit e, input logic [3:0] qq, input bit yy);
        reset = rst;
        en    = e;
        q     = qq;
        y     = yy;
        @(posedge clk);
        m_mis = 0;
        m_odd = 0;
        if (rst) begin
            m_have = 0; m_lock = 0; m_ref = 4'd0; m_refy = 0; m_run = 0; m_errs = 0;
        end else if (e) begin
            m_odd = qq[0];
            if (!m_have) begin
                m_have = 1;
                m_run  = 0;
            end else if (qq == predict(m_ref, m_refy)) begin
                if (!m_lock) begin
                    m_run++;
                    if (m_run == int'(LockLen)) m_lock = 1;
                end
            end else begin
                if (m_lock) begin
                    m_mis = 1;
                    m_errs++;
                end
                m_lock = 0;
                m_run  = 0;
            end
            m_ref  = qq;
            m_refy = yy;
        end
        m_expect = m_have ? predict(m_ref, m_refy) : 4'd0;
        #1;
    endtask

    task automatic test_reset;
        apply(1, 1, 4'd6, 0);
        apply(1, 0, 4'd0, 0);
        checks += 6;
        if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked got %0b want 0", locked); end
        if (mismatch !== 1'b0) begin errors++; $display("FAIL reset_mismatch got %0b want 0", mismatch); end
        if (odd_err !== 1'b0) begin errors++; $display("FAIL reset_odd got %0b want 0", odd_err); end
        if (err8 !== 8'd0) begin errors++; $display("FAIL reset_err got %0d want 0", err8); end
        if (err2 !== 2'd0) begin errors++; $display("FAIL reset_err2 got %0d want 0", err2); end
        if (expected !== 4'd0) begin errors++; $display("FAIL reset_expected got %0d want 0", expected); end
    endtask

    task automatic test_lock_up;
        logic [3:0] seq [4] = '{4'd0, 4'd2, 4'd4, 4'd6};
        for (int i = 0; i < 4; i++) begin
            apply(0, 1, seq[i], 0);
            checks += 3;
            if (locked !== m_lock) begin errors++; $display("FAIL lock_up_locked got %0b want %0b", locked, m_lock); end
            if (mismatch !== 1'b0) begin errors++; $display("FAIL lock_up_mismatch got %0b want 0", mismatch); end
            if (expected !== m_expect) begin errors++; $display("FAIL lock_up_expected got %0d want %0d", expected, m_expect); end
            if (i < 3) begin
                checks++;
                if (locked !== 1'b0) begin errors++; $display("FAIL lock_up_early got %0b want 0", locked); end
            end
        end
        checks += 2;
        if (locked !== 1'b1) begin errors++; $display("FAIL lock_up_final got %0b want 1", locked); end
        if (expected !== 4'd8) begin errors++; $display("FAIL lock_up_exp8 got %0d want 8", expected); end
    endtask

    task automatic test_wrap;
        logic [3:0] seq [6] = '{4'd8, 4'd10, 4'd12, 4'd14, 4'd0, 4'd2};
        for (int i = 0; i < 6; i++) begin
            apply(0, 1, seq[i], 0);
            checks += 3;
            if (locked !== 1'b1) begin errors++; $display("FAIL wrap_locked got %0b want 1", locked); end
            if (mismatch !== 1'b0) begin errors++; $display("FAIL wrap_mismatch got %0b want 0", mismatch); end
            if (expected !== m_expect) begin errors++; $display("FAIL wrap_expected got %0d want %0d", expected, m_expect); end
        end
    endtask

    task automatic test_down;
        logic [3:0] qs [7] = '{4'd4, 4'd2, 4'd0, 4'd14, 4'd12, 4'd10, 4'd12};
        bit         ys [7] = '{1, 1, 1, 1, 1, 0, 0};
        for (int i = 0; i < 7; i++) begin
            apply(0, 1, qs[i], ys[i]);
            checks += 3;
            if (locked !== 1'b1) begin errors++; $display("FAIL down_locked got %0b want 1", locked); end
            if (mismatch !== 1'b0) begin errors++; $display("FAIL down_mismatch got %0b want 0", mismatch); end
            if (expected !== m_expect) begin errors++; $display("FAIL down_expected got %0d want %0d", expected, m_expect); end
            if (i == 2) begin
                checks++;
                if (expected !== 4'd14) begin errors++; $display("FAIL down_wrap got %0d want 14", expected); end
            end
        end
    endtask

    task automatic test_mismatch;
        logic [3:0] seq [5] = '{4'd14, 4'd0, 4'd2, 4'd4, 4'd6};
        for (int i = 0; i < 5; i++) apply(0, 1, seq[i], 0);
        checks += 2;
        if (locked !== 1'b1) begin errors++; $display("FAIL mis_pre_locked got %0b want 1", locked); end
        if (expected !== 4'd8) begin errors++; $display("FAIL mis_pre_exp got %0d want 8", expected); end
        apply(0, 1, 4'd9, 0);
        checks += 4;
        if (mismatch !== 1'b1) begin errors++; $display("FAIL mis_pulse got %0b want 1", mismatch); end
        if (odd_err !== 1'b1) begin errors++; $display("FAIL mis_odd got %0b want 1", odd_err); end
        if (err8 !== 8'd1) begin errors++; $display("FAIL mis_err got %0d want 1", err8); end
        if (locked !== 1'b0) begin errors++; $display("FAIL mis_unlock got %0b want 0", locked); end
        // Wrong in ACQ: no pulse and no count change.
        apply(0, 1, 4'd10, 0);
        checks += 3;
        if (mismatch !== 1'b0) begin errors++; $display("FAIL mis_acq_pulse got %0b want 0", mismatch); end
        if (odd_err !== 1'b0) begin errors++; $display("FAIL mis_acq_odd got %0b want 0", odd_err); end
        if (err8 !== 8'd1) begin errors++; $display("FAIL mis_acq_err got %0d want 1", err8); end
        apply(0, 1, 4'd12, 0);
        apply(0, 1, 4'd14, 0);
        checks++;
        if (locked !== 1'b0) begin errors++; $display("FAIL relock_early got %0b want 0", locked); end
        apply(0, 1, 4'd0, 0);
        checks++;
        if (locked !== 1'b1) begin errors++; $display("FAIL relock got %0b want 1", locked); end
    endtask

    task automatic test_saturate;
        for (int k = 0; k < 5; k++) begin
            apply(0, 1, m_expect + 4'd4, 0);
            for (int g = 0; g < 3; g++) apply(0, 1, m_expect, 0);
            checks += 3;
            if (err2 !== sat2(m_errs)) begin errors++; $display("FAIL sat_err2 got %0d want %0d", err2, sat2(m_errs)); end
            if (err8 !== sat8(m_errs)) begin errors++; $display("FAIL sat_err8 got %0d want %0d", err8, sat8(m_errs)); end
            if (locked2 !== m_lock) begin errors++; $display("FAIL sat_locked got %0b want %0b", locked2, m_lock); end
        end
        checks += 2;
        if (err2 !== 2'd3) begin errors++; $display("FAIL sat_hold got %0d want 3", err2); end
        if (err8 !== 8'd6) begin errors++; $display("FAIL sat_err8_total got %0d want 6", err8); end
    endtask

    task automatic test_reset_locked;
        apply(1, 1, m_expect, 0);
        checks += 5;
        if (locked !== 1'b0) begin errors++; $display("FAIL rstlk_locked got %0b want 0", locked); end
        if (mismatch !== 1'b0) begin errors++; $display("FAIL rstlk_mismatch got %0b want 0", mismatch); end
        if (odd_err !== 1'b0) begin errors++; $display("FAIL rstlk_odd got %0b want 0", odd_err); end
        if (err8 !== 8'd0) begin errors++; $display("FAIL rstlk_err got %0d want 0", err8); end
        if (expected !== 4'd0) begin errors++; $display("FAIL rstlk_exp got %0d want 0", expected); end
        // Still EMPTY: an idle cycle must leave expected at 0.
        apply(0, 0, 4'd4, 0);
        checks++;
        if (expected !== 4'd0) begin errors++; $display("FAIL rstlk_empty got %0d want 0", expected); end
    endtask

    task automatic test_hold;
        logic       s_lock;
        logic [7:0] s_err;
        logic [3:0] s_exp;
        logic [3:0] seq [4] = '{4'd4, 4'd6, 4'd8, 4'd10};
        for (int i = 0; i < 4; i++) apply(0, 1, seq[i], 0);
        s_lock = locked;
        s_err  = err8;
        s_exp  = expected;
        checks++;
        if (s_lock !== 1'b1) begin errors++; $display("FAIL hold_pre got %0b want 1", s_lock); end
        for (int i = 0; i < 4; i++) begin
            apply(0, 0, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
            checks += 5;
            if (locked !== s_lock) begin errors++; $display("FAIL hold_locked got %0b want %0b", locked, s_lock); end
            if (err8 !== s_err) begin errors++; $display("FAIL hold_err got %0d want %0d", err8, s_err); end
            if (expected !== s_exp) begin errors++; $display("FAIL hold_exp got %0d want %0d", expected, s_exp); end
            if (mismatch !== 1'b0) begin errors++; $display("FAIL hold_mismatch got %0b want 0", mismatch); end
            if (odd_err !== 1'b0) begin errors++; $display("FAIL hold_odd got %0b want 0", odd_err); end
        end
        apply(0, 1, 4'd12, 0);
        checks++;
        if (locked !== 1'b1) begin errors++; $display("FAIL hold_resume got %0b want 1", locked); end
    endtask

    task automatic test_random;
        bit         rst, e, yy;
        logic [3:0] qq;
        for (int n = 0; n < 600; n++) begin
            rst = ($urandom_range(0, 99) < 2);
            e   = ($urandom_range(0, 3) != 0);
            yy  = 1'($urandom_range(0, 1));
            qq  = ($urandom_range(0, 9) < 8) ? m_expect : 4'($urandom_range(0, 15));
            apply(rst, e, qq, yy);
            checks += 7;
            if (locked !== m_lock) begin errors++; $display("FAIL rnd_locked n=%0d got %0b want %0b", n, locked, m_lock); end
            if (mismatch !== m_mis) begin errors++; $display("FAIL rnd_mismatch n=%0d got %0b want %0b", n, mismatch, m_mis); end
            if (odd_err !== m_odd) begin errors++; $display("FAIL rnd_odd n=%0d got %0b want %0b", n, odd_err, m_odd); end
            if (err8 !== sat8(m_errs)) begin errors++; $display("FAIL rnd_err8 n=%0d got %0d want %0d", n, err8, sat8(m_errs)); end
            if (err2 !== sat2(m_errs)) begin errors++; $display("FAIL rnd_err2 n=%0d got %0d want %0d", n, err2, sat2(m_errs)); end
            if (expected !== m_expect) begin errors++; $display("FAIL rnd_exp n=%0d got %0d want %0d", n, expected, m_expect); end
            if (mismatch2 !== m_mis) begin errors++; $display("FAIL rnd_mismatch2 n=%0d got %0b want %0b", n, mismatch2, m_mis); end
        end
    endtask

    initial begin
        test_reset();
        test_lock_up();
        test_wrap();
        test_down();
        test_mismatch();
        test_saturate();
        test_reset_locked();
        test_hold();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
